fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined CPU. It owns the PC register and drives the BTB read port and the instruction memory. It forms the next PC from execute redirect, stall, BTB prediction, or sequential increment. It then delivers a fetch packet (pc, instr, prediction) to decode, and holds that packet across stalls.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_instr_hold.sv | 43 ++++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch constants and the fetch packet type
package fetch_stage_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] PC_INC_DEFAULT   = 16'd2;

  // One fetched instruction as seen by decode and execute.
  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        pred_taken;
    logic [15:0] pred_target;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_instr_hold.sv
// rtl/fetch_instr_hold.sv - captures the in-flight imem word while decode stalls
module fetch_instr_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [15:0] rdata_i,
  output logic [15:0] instr_o
);

  logic        hold_valid_q, hold_valid_d;
  logic [15:0] instr_hold_q, instr_hold_d;

  // The first stall cycle still sees the word for the packet in flight;
  // later cycles see imem re-reading the stalled PC, so only capture once.
  always_comb begin
    hold_valid_d = hold_valid_q;
    instr_hold_d = instr_hold_q;
    if (flush_i) begin
      hold_valid_d = 1'b0;
    end else if (stall_i) begin
      if (!hold_valid_q) begin
        instr_hold_d = rdata_i;
        hold_valid_d = 1'b1;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      instr_hold_q <= 16'h0000;
    end else begin
      hold_valid_q <= hold_valid_d;
      instr_hold_q <= instr_hold_d;
    end
  end

  assign instr_o = hold_valid_q ? instr_hold_q : rdata_i;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC selection and decode packet register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [15:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_btb_rPC,
  input  logic        i_btb_valid,
  input  logic [15:0] i_btb_BT,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_valid,
  output logic [15:0] o_pc,
  output logic [15:0] o_instr,
  output logic        o_pred_taken,
  output logic [15:0] o_pred_target
);

  logic [15:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic        out_pred_taken_q, out_pred_taken_d;
  logic [15:0] out_pred_target_q, out_pred_target_d;
  logic [15:0] instr;
  fetch_pkt_t  pkt;

  always_comb begin
    pc_d              = pc_q;
    out_valid_d       = out_valid_q;
    out_pc_d          = out_pc_q;
    out_pred_taken_d  = out_pred_taken_q;
    out_pred_target_d = out_pred_target_q;
    if (i_redirect) begin
      pc_d        = i_redirect_pc;
      out_valid_d = 1'b0;
    end else if (!i_stall) begin
      pc_d              = i_btb_valid ? i_btb_BT : pc_q + PC_INC;
      out_valid_d       = 1'b1;
      out_pc_d          = pc_q;
      out_pred_taken_d  = i_btb_valid;
      out_pred_target_d = i_btb_valid ? i_btb_BT : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q              <= RESET_PC;
      out_valid_q       <= 1'b0;
      out_pc_q          <= 16'h0000;
      out_pred_taken_q  <= 1'b0;
      out_pred_target_q <= 16'h0000;
    end else begin
      pc_q              <= pc_d;
      out_valid_q       <= out_valid_d;
      out_pc_q          <= out_pc_d;
      out_pred_taken_q  <= out_pred_taken_d;
      out_pred_target_q <= out_pred_target_d;
    end
  end

  fetch_instr_hold u_instr_hold (
    .clk     (clk),
    .reset   (reset),
    .flush_i (i_redirect),
    .stall_i (i_stall),
    .rdata_i (i_imem_rdata),
    .instr_o (instr)
  );

  always_comb begin
    pkt.valid       = out_valid_q;
    pkt.pc          = out_pc_q;
    pkt.instr       = instr;
    pkt.pred_taken  = out_pred_taken_q;
    pkt.pred_target = out_pred_target_q;
  end

  assign o_btb_rPC     = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_valid       = pkt.valid;
  assign o_pc          = pkt.pc;
  assign o_instr       = pkt.instr;
  assign o_pred_taken  = pkt.pred_taken;
  assign o_pred_target = pkt.pred_target;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] o_btb_rPC;
  logic        i_btb_valid;
  logic [15:0] i_btb_BT;
  logic [15:0] o_imem_addr;
  logic [15:0] i_imem_rdata = 16'h0000;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_pc = 16'h0000;
  logic        o_valid;
  logic [15:0] o_pc;
  logic [15:0] o_instr;
  logic        o_pred_taken;
  logic [15:0] o_pred_target;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [65536];
  bit          btb_hit [65536];
  logic [15:0] btb_bt [65536];

  // Model: address being fetched, and the packet decode should be seeing.
  logic [15:0] m_pc;
  logic        m_valid;
  logic [15:0] m_opc;
  logic        m_pt;
  logic [15:0] m_tgt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .o_btb_rPC     (o_btb_rPC),
    .i_btb_valid   (i_btb_valid),
    .i_btb_BT      (i_btb_BT),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (i_imem_rdata),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_pred_taken  (o_pred_taken),
    .o_pred_target (o_pred_target)
  );

  always @(*) begin
    i_btb_valid = btb_hit[o_btb_rPC];
    i_btb_BT    = btb_bt[o_btb_rPC];
  end

  always @(posedge clk) i_imem_rdata <= mem[o_imem_addr];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    reset = rst;
    i_stall = st;
    i_redirect = rd;
    i_redirect_pc = rpc;
    @(posedge clk);
    if (rst) begin
      m_pc = 16'h0000; m_valid = 1'b0; m_opc = 16'h0000; m_pt = 1'b0; m_tgt = 16'h0000;
    end else if (rd) begin
      m_valid = 1'b0;
      m_pc = rpc;
    end else if (!st) begin
      m_valid = 1'b1;
      m_opc = m_pc;
      m_pt = btb_hit[m_pc];
      m_tgt = btb_hit[m_pc] ? btb_bt[m_pc] : 16'h0000;
      m_pc = btb_hit[m_pc] ? btb_bt[m_pc] : m_pc + 16'd2;
    end
    #1;
    check("btb_addr", o_btb_rPC, m_pc);
    check("imem_addr", o_imem_addr, m_pc);
    check("valid", {15'd0, o_valid}, {15'd0, m_valid});
    if (rst) begin
      check("rst_pc", o_pc, 16'h0000);
      check("rst_pred_taken", {15'd0, o_pred_taken}, 16'h0000);
      check("rst_pred_target", o_pred_target, 16'h0000);
    end else if (m_valid) begin
      check("pc", o_pc, m_opc);
      check("instr", o_instr, mem[m_opc]);
      check("pred_taken", {15'd0, o_pred_taken}, {15'd0, m_pt});
      check("pred_target", o_pred_target, m_tgt);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      btb_hit[a] = 1'b0;
      btb_bt[a] = 16'h0000;
    end
    mem[6] = 16'hA5A5;

    // Sequential run, then a long stall on the packet at 0006.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("stall_entry_pc", o_pc, 16'h0006);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      check("stall_hold_instr", o_instr, 16'hA5A5);
    end
    step(0, 0, 0, 0);
    check("after_stall_pc", o_pc, 16'h0008);

    // Redirect during stall, then wrap past FFFE.
    step(0, 1, 0, 0);
    step(0, 1, 1, 16'h0100);
    step(0, 0, 0, 0);
    check("redirect_pc", o_pc, 16'h0100);
    step(0, 0, 1, 16'hFFFE);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("wrap_pc", o_pc, 16'h0000);

    // BTB hit at 0004 -> 0040 with no bubble.
    btb_hit[4] = 1'b1;
    btb_bt[4] = 16'h0040;
    step(0, 0, 1, 16'h0004);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("btb_seq_pc", o_pc, 16'h0042);

    // Reset in the middle of a stall that holds a word.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check("post_reset_pc", o_pc, 16'h0000);
    step(0, 0, 0, 0);

    // Random traffic over a small region with a populated BTB.
    for (int i = 0; i < 48; i++) begin
      int unsigned a;
      a = $urandom_range(0, 1023) * 2;
      btb_hit[a] = 1'b1;
      btb_bt[a] = 16'($urandom_range(0, 1023) * 2);
    end
    btb_hit[16'hFFFE] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic rst, st, rd;
      logic [15:0] rpc;
      rst = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom_range(0, 1023) * 2);
      step(rst, st, rd, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
